avalon_ram_agent: RTL and testbench

AVALON_RAM_AGENT -- requirements
Module: avalon_ram_agent

---
 rtl/avalon_ram_agent_if.sv | 24 ++
 rtl/avalon_ram_agent.sv | 120 ++++++++++++
 tb/tb_avalon_ram_agent.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_agent_if.sv
// AvalonMmRw: 32-bit Avalon-MM read/write bundle.
//   Agent modport: address/read/write/byteenable/host_to_agent in,
//                  agent_to_host/waitrequest/readdatavalid out.
//   Host modport : mirror image of Agent.
interface AvalonMmRw;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport Agent (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport Host (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_ram_agent.sv
// avalon_ram_agent: single-outstanding Avalon-MM RAM agent with fixed
// read/write latency.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset (storage is not cleared)
//   port : AvalonMmRw.Agent; waitrequest low only in the completion (RESP)
//          cycle, readdatavalid high only in the RESP cycle of a read.
// A request is latched on acceptance in IDLE; the host may drop or change
// its signals afterwards. Writes commit on the edge that ends RESP.
module avalon_ram_agent #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input logic       clk,
  input logic       rst,
  AvalonMmRw.Agent  port
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] RL_M1 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WL_M1 = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   req_idx;
  logic            rd_req, wr_req;
  logic            addr_unused;

  // Byte offset and bits above the index are don't-care: addresses wrap.
  assign req_idx     = port.address[AW+1:2];
  assign addr_unused = ^{port.address[31:AW+2], port.address[1:0]};
  assign rd_req      = port.read & ~port.write;
  assign wr_req      = port.write & ~port.read;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          idx_d   = req_idx;
          is_wr_d = wr_req;
          cnt_d   = wr_req ? WL_M1 : RL_M1;
          if (wr_req) begin
            be_d    = port.byteenable;
            wdata_d = port.host_to_agent;
          end
          if (cnt_d == 4'd0) begin
            state_d = RESP;
            // Latency-1 read: the index is not latched yet, use the live one.
            if (rd_req) rdata_d = mem_q[req_idx];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Counter hits 0 on the same edge that enters RESP, so the request
        // seen at cycle t completes at exactly t+LATENCY.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (!is_wr_q) rdata_d = mem_q[idx_q];
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset. Reset forces state_q to IDLE asynchronously, so an
  // aborted write can never reach this commit.
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign port.waitrequest   = (state_q != RESP);
  assign port.readdatavalid = (state_q == RESP) && !is_wr_q;
  assign port.agent_to_host = rdata_q;

endmodule

// File: tb/tb_avalon_ram_agent.sv
module tb_avalon_ram_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] h_addr, h_wdata;
  logic        h_read, h_write;
  logic [3:0]  h_be;
  int          sel;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  AvalonMmRw b0();
  AvalonMmRw b1();

  assign b0.address = h_addr;       assign b1.address = h_addr;
  assign b0.read = h_read;          assign b1.read = h_read;
  assign b0.write = h_write;        assign b1.write = h_write;
  assign b0.byteenable = h_be;      assign b1.byteenable = h_be;
  assign b0.host_to_agent = h_wdata; assign b1.host_to_agent = h_wdata;

  // dut0: defaults (RL=2, WL=1). dut1: RL=1, WL=3.
  avalon_ram_agent #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .WRITE_LATENCY(1))
    dut0 (.clk(clk), .rst(rst), .port(b0));
  avalon_ram_agent #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(3))
    dut1 (.clk(clk), .rst(rst), .port(b1));

  logic        o_wait, o_rdv;
  logic [31:0] o_data;
  assign o_wait = (sel != 0) ? b1.waitrequest   : b0.waitrequest;
  assign o_rdv  = (sel != 0) ? b1.readdatavalid : b0.readdatavalid;
  assign o_data = (sel != 0) ? b1.agent_to_host : b0.agent_to_host;

  // Reference model for dut0: plain word array, byte-merge on write.
  logic [31:0] mdl [1024];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge with the selected DUT in IDLE. Drives one
  // request, drops/scrambles it after acceptance, waits for RESP, checks
  // latency and outputs, then steps one cycle into IDLE.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] data, input int exp_lat, input bit chk_data,
                     input logic [31:0] exp_data, input string nm);
    logic [31:0] prev, held;
    int n;
    bit done;
    prev = o_data;
    h_addr = addr; h_read = !wr; h_write = wr; h_be = be; h_wdata = data;
    n = 0; done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        h_read = 0; h_write = 0;
        h_addr = $urandom; h_wdata = $urandom; h_be = 4'($urandom);
      end
      if (!o_wait) done = 1;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_rdv"}, 32'(o_rdv), 32'(!wr));
    if (wr) chk({nm, "_hold_wr"}, o_data, prev);
    else if (chk_data) chk({nm, "_data"}, o_data, exp_data);
    held = o_data;
    @(posedge clk); #1;
    chk({nm, "_idle_wait"}, 32'(o_wait), 32'd1);
    chk({nm, "_idle_rdv"}, 32'(o_rdv), 32'd0);
    chk({nm, "_idle_hold"}, o_data, held);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int n;
    bit wr;
    int idx;
    logic [31:0] a, d;
    logic [3:0] be;

    tbl[0]  = '{1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 32'h10,   4'h1, 32'h000000AA, 32'h0};
    tbl[3]  = '{0, 32'h10,   4'h0, 32'h0,        32'hDEADBEAA};
    tbl[4]  = '{1, 32'h10,   4'h3, 32'h00001234, 32'h0};
    tbl[5]  = '{0, 32'h10,   4'h0, 32'h0,        32'hDEAD1234};
    tbl[6]  = '{1, 32'h1000, 4'hF, 32'h00000055, 32'h0};
    tbl[7]  = '{0, 32'h0,    4'h0, 32'h0,        32'h00000055};
    tbl[8]  = '{1, 32'h14,   4'hF, 32'h01234567, 32'h0};
    tbl[9]  = '{1, 32'h14,   4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[10] = '{0, 32'h17,   4'h0, 32'h0,        32'h01234567};
    tbl[11] = '{1, 32'hFFC,  4'hF, 32'hCAFEF00D, 32'h0};

    sel = 0;
    rst = 0; h_addr = 0; h_read = 0; h_write = 0; h_be = 0; h_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst0_wait", 32'(b0.waitrequest), 32'd1);
    chk("rst0_rdv",  32'(b0.readdatavalid), 32'd0);
    chk("rst0_data", b0.agent_to_host, 32'd0);
    chk("rst1_wait", 32'(b1.waitrequest), 32'd1);
    chk("rst1_rdv",  32'(b1.readdatavalid), 32'd0);
    chk("rst1_data", b1.agent_to_host, 32'd0);
    rst = 1;
    @(posedge clk); #1;

    // Directed table on dut0
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data,
          tbl[i].wr ? 1 : 2, 1, tbl[i].exp, $sformatf("tbl%0d", i));
      if (tbl[i].wr) mdl[widx(tbl[i].addr)] = merge(mdl[widx(tbl[i].addr)], tbl[i].data, tbl[i].be);
    end
    txn(0, 32'h7FFC, 4'h0, 32'h0, 2, 1, 32'hCAFEF00D, "wrap_hi");

    // Randomized traffic against the model: prefill words 0..15 then mix
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = ($urandom & 32'hFFFF_F003) | (32'(i) << 2);
      txn(1, a, 4'hF, d, 1, 0, 32'h0, "fill");
      mdl[i] = d;
    end
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
      wr = 1'($urandom);
      be = 4'($urandom);
      d = $urandom;
      if (wr) begin
        txn(1, a, be, d, 1, 0, 32'h0, $sformatf("rnd%0d_w", i));
        mdl[idx] = merge(mdl[idx], d, be);
      end else begin
        txn(0, a, 4'h0, 32'h0, 2, 1, mdl[idx], $sformatf("rnd%0d_r", i));
      end
    end

    // read and write together: nothing accepted
    h_addr = 32'h10; h_read = 1; h_write = 1; h_be = 4'hF; h_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("both%0d_wait", i), 32'(b0.waitrequest), 32'd1);
      chk($sformatf("both%0d_rdv", i), 32'(b0.readdatavalid), 32'd0);
    end
    h_read = 0; h_write = 0;
    @(posedge clk); #1;
    txn(0, 32'h10, 4'h0, 32'h0, 2, 1, mdl[4], "both_mem");

    // back-to-back reads with read held across RESP
    h_addr = 32'h10; h_read = 1; h_write = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (b0.waitrequest && n < 20);
    chk("b2b1_lat", n, 2);
    chk("b2b1_rdv", 32'(b0.readdatavalid), 32'd1);
    chk("b2b1_data", b0.agent_to_host, mdl[4]);
    h_addr = 32'h14;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (b0.waitrequest && n < 20);
    chk("b2b2_lat", n, 3);
    chk("b2b2_rdv", 32'(b0.readdatavalid), 32'd1);
    chk("b2b2_data", b0.agent_to_host, mdl[5]);
    h_read = 0;

    // dut1 (RL=1, WL=3): latency, read-after-write, reset abort
    repeat (6) @(posedge clk);
    #1;
    sel = 1;
    @(posedge clk); #1;
    txn(1, 32'h20, 4'hF, 32'h11112222, 3, 0, 32'h0, "d1_w");
    txn(0, 32'h20, 4'h0, 32'h0, 1, 1, 32'h11112222, "d1_raw");
    h_addr = 32'h20; h_write = 1; h_be = 4'hF; h_wdata = 32'h99999999;
    @(posedge clk); #1;
    h_write = 0;
    @(posedge clk); #1;
    chk("d1_busy_wait", 32'(b1.waitrequest), 32'd1);
    rst = 0;
    #1;
    chk("d1_rst_wait", 32'(b1.waitrequest), 32'd1);
    chk("d1_rst_rdv",  32'(b1.readdatavalid), 32'd0);
    chk("d1_rst_data", b1.agent_to_host, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    txn(0, 32'h20, 4'h0, 32'h0, 1, 1, 32'h11112222, "d1_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
